// File: rtl/bp_btb_param.sv
// Parametrised branch target buffer with per-entry saturating direction counters.
// Define BP_GSHARE_EN to index the table with PC bits XORed with a global history register.
module bp_btb_param #(
  parameter int W     = 32,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     pc,
  output logic             predict_j_taken,
  output logic [W-1:0]     predict_addr,
  output logic [IDX_W-1:0] predict_ghr,
  input  logic             upd,
  input  logic [W-1:0]     upd_src_pc,
  input  logic             upd_taken,
  input  logic [W-1:0]     upd_target,
  input  logic [IDX_W-1:0] upd_ghr,
  input  logic             clear
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 2 + TAG_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1) << (CNT_W - 1);

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [W-1:0]     tgt_q   [DEPTH];
  logic [CNT_W-1:0] cnt_q   [DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             lk_hit;
  logic             up_hit;
  logic             lk_taken;
  logic [W-1:0]     pc_inc;

  logic             ent_we;
  logic [W-1:0]     ent_tgt_d;
  logic [CNT_W-1:0] ent_cnt_d;
  logic [IDX_W-1:0] ghr_d;

  // Bit-level sink for the parts of the PC buses that never reach the table.
  logic unused_bits;
  assign unused_bits = ^{pc, upd_src_pc, upd_ghr};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  assign lk_idx = pc[IDX_W+1:2] ^ ghr_q;
  assign up_idx = upd_src_pc[IDX_W+1:2] ^ upd_ghr;
  assign ghr_d  = upd ? ((ghr_q << 1) | IDX_W'(upd_taken)) : ghr_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign predict_ghr = rst ? '0 : ghr_q;
`else
  assign lk_idx      = pc[IDX_W+1:2];
  assign up_idx      = upd_src_pc[IDX_W+1:2];
  assign ghr_d       = '0;
  assign predict_ghr = '0;
`endif

  assign lk_tag = pc[TAG_HI:TAG_LO];
  assign up_tag = upd_src_pc[TAG_HI:TAG_LO];

  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pc_inc   = pc + W'(4);

  // Table contents may be stale during the first reset cycle, so gate on rst.
  assign predict_j_taken = !rst && lk_taken;
  assign predict_addr    = predict_j_taken ? tgt_q[lk_idx] : pc_inc;

  always_comb begin
    ent_we    = 1'b0;
    ent_tgt_d = tgt_q[up_idx];
    ent_cnt_d = cnt_q[up_idx];
    if (upd) begin
      if (up_hit) begin
        ent_we = 1'b1;
        if (upd_taken) begin
          ent_tgt_d = upd_target;
          if (cnt_q[up_idx] != CNT_MAX) begin
            ent_cnt_d = cnt_q[up_idx] + CNT_W'(1);
          end
        end else if (cnt_q[up_idx] != '0) begin
          ent_cnt_d = cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        ent_we    = 1'b1;
        ent_tgt_d = upd_target;
        ent_cnt_d = CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (ent_we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= ent_tgt_d;
      cnt_q[up_idx]   <= ent_cnt_d;
    end
  end

endmodule
